// File: rtl/bellek_pkg.sv
// -----------------------------------------------------------------------------
// bellek_pkg
// Shared definitions for the bellek memory controller:
//   - host command opcodes (OP_WRITE, OP_READ, OP_LOAD_KEY, OP_ROTATE)
//   - controller FSM state encoding (state_t)
//   - key_addr(): location of the key slot for a given address width
// Optional build macro BELLEK_AUTOKEY_EN adds the ST_AUTOKEY state.
// -----------------------------------------------------------------------------
package bellek_pkg;

    localparam logic [1:0] OP_WRITE    = 2'b00;
    localparam logic [1:0] OP_READ     = 2'b01;
    localparam logic [1:0] OP_LOAD_KEY = 2'b10;
    localparam logic [1:0] OP_ROTATE   = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR      = 4'd1,
        ST_KEY     = 4'd2,
        ST_ERR     = 4'd3,
        ST_RD      = 4'd4,
        ST_RD_CAP  = 4'd5,
        ST_ROT_RD  = 4'd6,
        ST_ROT_CAP = 4'd7,
        ST_ROT_WR  = 4'd8,
        ST_ROT_KEY = 4'd9
`ifdef BELLEK_AUTOKEY_EN
        ,
        ST_AUTOKEY = 4'd10
`endif
    } state_t;

    // The top word of the address space is reserved for the key.
    function automatic int key_addr(input int aw);
        return (1 << aw) - 1;
    endfunction

endpackage

// File: rtl/bellek_ctrl.sv
// -----------------------------------------------------------------------------
// bellek_ctrl
// Host-side initiator for the XOR-keyed bellek memory. Converts single host
// commands (WRITE, READ, LOAD_KEY, ROTATE_KEY) into memory cycle sequences.
// ROTATE_KEY walks every data word, re-encrypting it under the new key, then
// writes the new key, so host-visible plaintext is unchanged.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   host command handshake (ready only in IDLE)
//   cmd_op/addr/data      opcode, word address, write data or new key
//   rsp_valid/err/data    one-cycle completion pulse, error flag, read data
//   busy                  inverse of cmd_ready
//   mem_d/a/we/ke         memory-side drive (registered)
//   mem_q                 memory read data, valid the cycle after a read edge
//
// Build macro: BELLEK_AUTOKEY_EN -- when defined, the controller loads key 0
// into the memory in the first cycle after reset, so the memory key matches
// the internal key shadow without a host LOAD_KEY.
// -----------------------------------------------------------------------------
import bellek_pkg::*;

module bellek_ctrl #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic [DW-1:0] mem_d,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic          mem_ke,
    input  logic [DW-1:0] mem_q
);

    localparam logic [AW-1:0] KEY_ADDR  = AW'(key_addr(AW));
    localparam logic [AW-1:0] LAST_ADDR = KEY_ADDR - 1'b1;

`ifdef BELLEK_AUTOKEY_EN
    localparam state_t RST_STATE = ST_AUTOKEY;
    localparam logic   RST_READY = 1'b0;
`else
    localparam state_t RST_STATE = ST_IDLE;
    localparam logic   RST_READY = 1'b1;
`endif

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;             // rotation word counter
    logic [DW-1:0] k2_reg, k2_next;                 // new key during rotation
    logic [DW-1:0] key_shadow_reg, key_shadow_next; // key currently in memory

    logic [DW-1:0] mem_d_reg, mem_d_next;
    logic [AW-1:0] mem_a_reg, mem_a_next;
    logic          mem_we_reg, mem_we_next;
    logic          mem_ke_reg, mem_ke_next;
    logic          rsp_valid_reg, rsp_valid_next;
    logic          rsp_err_reg, rsp_err_next;
    logic [DW-1:0] rsp_data_reg, rsp_data_next;
    logic          cmd_ready_reg, cmd_ready_next;

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        k2_next         = k2_reg;
        key_shadow_next = key_shadow_reg;
        // Memory strobes and the response default to inactive every cycle;
        // each state only raises what the following cycle needs.
        mem_d_next      = '0;
        mem_a_next      = '0;
        mem_we_next     = 1'b0;
        mem_ke_next     = 1'b0;
        rsp_valid_next  = 1'b0;
        rsp_err_next    = 1'b0;
        rsp_data_next   = '0;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            if (cmd_addr == KEY_ADDR) begin
                                state_next = ST_ERR;
                            end else begin
                                state_next  = ST_WR;
                                mem_a_next  = cmd_addr;
                                mem_d_next  = cmd_data;
                                mem_we_next = 1'b1;
                            end
                        end
                        OP_READ: begin
                            if (cmd_addr == KEY_ADDR) begin
                                state_next = ST_ERR;
                            end else begin
                                state_next = ST_RD;
                                mem_a_next = cmd_addr;
                            end
                        end
                        OP_LOAD_KEY: begin
                            state_next  = ST_KEY;
                            mem_d_next  = cmd_data;
                            mem_ke_next = 1'b1;
                        end
                        default: begin
                            state_next = ST_ROT_RD;
                            addr_next  = '0;
                            k2_next    = cmd_data;
                        end
                    endcase
                end
            end
            ST_WR, ST_ERR: begin
                state_next     = ST_IDLE;
                rsp_valid_next = 1'b1;
                rsp_err_next   = (state_reg == ST_ERR);
            end
            ST_KEY: begin
                state_next      = ST_IDLE;
                key_shadow_next = mem_d_reg;
                rsp_valid_next  = 1'b1;
            end
            ST_RD: begin
                state_next = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                state_next     = ST_IDLE;
                rsp_valid_next = 1'b1;
                rsp_data_next  = mem_q;
            end
            ST_ROT_RD: begin
                state_next = ST_ROT_CAP;
                mem_a_next = addr_reg;
            end
            ST_ROT_CAP: begin
                // mem_q is plaintext under K1; the write below is encrypted by
                // the memory with K1 again, so storing q^K1^K2 leaves the
                // word encrypted under K2 once the key is switched.
                state_next  = ST_ROT_WR;
                mem_a_next  = addr_reg;
                mem_d_next  = mem_q ^ key_shadow_reg ^ k2_reg;
                mem_we_next = 1'b1;
            end
            ST_ROT_WR: begin
                // Counter stops at the last data word; the key slot is only
                // ever written through the key strobe.
                if (addr_reg == LAST_ADDR) begin
                    state_next  = ST_ROT_KEY;
                    mem_d_next  = k2_reg;
                    mem_ke_next = 1'b1;
                end else begin
                    state_next = ST_ROT_RD;
                    addr_next  = addr_reg + 1'b1;
                    mem_a_next = addr_reg + 1'b1;
                end
            end
            ST_ROT_KEY: begin
                state_next      = ST_IDLE;
                key_shadow_next = k2_reg;
                rsp_valid_next  = 1'b1;
            end
`ifdef BELLEK_AUTOKEY_EN
            ST_AUTOKEY: begin
                state_next = ST_IDLE;
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        cmd_ready_next = (state_next == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= RST_STATE;
            addr_reg       <= '0;
            k2_reg         <= '0;
            key_shadow_reg <= '0;
            mem_d_reg      <= '0;
            mem_a_reg      <= '0;
            mem_we_reg     <= 1'b0;
            mem_ke_reg     <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_data_reg   <= '0;
            cmd_ready_reg  <= RST_READY;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            k2_reg         <= k2_next;
            key_shadow_reg <= key_shadow_next;
            mem_d_reg      <= mem_d_next;
            mem_a_reg      <= mem_a_next;
            mem_we_reg     <= mem_we_next;
            mem_ke_reg     <= mem_ke_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_err_reg    <= rsp_err_next;
            rsp_data_reg   <= rsp_data_next;
            cmd_ready_reg  <= cmd_ready_next;
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign busy      = ~cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_data  = rsp_data_reg;
    assign mem_d     = mem_d_reg;
    assign mem_a     = mem_a_reg;
    assign mem_we    = mem_we_reg;

`ifdef BELLEK_AUTOKEY_EN
    // Reset parks the FSM in AUTOKEY; the key strobe is gated by rst_n so the
    // memory is left alone while reset is held and keyed with 0 (mem_d is 0)
    // in exactly the first cycle after release.
    assign mem_ke = mem_ke_reg | ((state_reg == ST_AUTOKEY) & rst_n);
`else
    assign mem_ke = mem_ke_reg;
`endif

endmodule
